bpsk_modulator: RTL
===================

// Module: bpsk_modulator
// PURPOSE
//  Downstream of the packet bit serializer: consumes one data bit per symbol period and produces
//  signed 8-bit BPSK carrier samples for the DAC. Carrier comes from a 64-entry sine ROM
//  stepped by a phase accumulator. Data bit selects carrier polarity.
//  Bit requests go upstream through a valid/ready handshake, so symbol timing is set here.
// PARAMETERS
//  SAMPLES_PER_SYMBOL  32  samples per data bit; legal 2..256; must match the serializer's WAVELENGTH
//  PHASE_STEP          4   ROM index advance per sample (carrier = PHASE_STEP/64 cycles per sample); 1..32
// PORTS
//  clock         in   1  system clock, all logic on rising edge
//  reset         in   1  synchronous, active-high
//  sample_en     in   1  sample-rate strobe; one output sample per cycle where high
//  bit_in        in   1  data bit from serializer
//  bit_valid     in   1  bit_in is valid
//  bit_ready     out  1  block will accept bit_in this cycle
//  sample_out    out  8  signed two's-complement carrier sample
//  sample_valid  out  1  sample_out updated this cycle
//  active        out  1  high while a symbol is being transmitted
// BEHAVIOUR
//  Reset: state=IDLE; phase=0; sample_cnt=0; polarity=0; sample_out=0; sample_valid=0; active=0.
//  ROM[k] = round(127*sin(2*pi*k/64)), k=0..63; ROM[0]=0, ROM[16]=127, ROM[48]=-127. |ROM|<=127, so negation never overflows.
//  Handshake: transfer when bit_valid && bit_ready at a rising edge. bit_in/bit_valid are ignored when bit_ready=0.
//  bit_ready (combinational) = (state==IDLE) || (state==SYMBOL && sample_en && sample_cnt==SAMPLES_PER_SYMBOL-1).
//  FSM IDLE:
//   - Transfer -> SYMBOL; load polarity from bit (0 -> +sin, 1 -> -sin); phase=0; sample_cnt=0.
//   - No transfer: phase and sample_cnt are held at 0.
//  FSM SYMBOL, each sample_en cycle:
//   - sample_out <= polarity ? -ROM[phase] : ROM[phase]; phase <= (phase+PHASE_STEP) mod 64 (6-bit wrap).
//   - sample_cnt increments. On the last sample (cnt==SAMPLES_PER_SYMBOL-1):
//     - Transfer: load new polarity, cnt=0, phase keeps running (continuous carrier across symbols).
//     - No transfer: -> IDLE.
//  sample_en low: state, phase, counter, outputs frozen; sample_valid=0.
//  sample_valid <= sample_en (every state). In IDLE, sample_out <= 0 on each sample_en.
//  active = (state==SYMBOL), registered.
//  Latency: first sample of an accepted bit is registered on the first sample_en cycle after the transfer.
//   It is visible on sample_out the cycle after that edge. Symbol length is exactly SAMPLES_PER_SYMBOL samples.
//  Back-to-back bits: no gap samples and no phase reset between symbols.
//  Reset mid-symbol: the next edge returns all state/outputs to reset values. The partially sent symbol is dropped.
//  Counter width: 8 bits; SAMPLES_PER_SYMBOL=256 wraps 255->0.
// CONFIGURATION
//  DBPSK_DIFF_ENCODE_EN defined:
//   - Differential encoding: on each transfer, polarity <= polarity ^ bit_in.
//   - polarity clears to 0 on reset and on entering IDLE.
//  DBPSK_DIFF_ENCODE_EN undefined: polarity <= bit_in (absolute BPSK).
// TESTING (SAMPLES_PER_SYMBOL=4, PHASE_STEP=16, sample_en=1 unless stated)
//  1. Reset, then bit 0 offered -> sample_out 0,127,0,-127; active high 4 cycles; then IDLE, sample_out=0.
//  2. Bits 0 then 1 back-to-back -> 0,127,0,-127,0,-127,0,127 with no gap; bit_ready high on cycles 4 and 8 only.
//  3. sample_en toggled 1,0,1,0 during bit 0 -> same 4 sample values spread over 8 cycles; sample_valid=1,0,1,0.
//  4. Assert reset on sample 2 of a symbol -> next cycle sample_out=0, active=0, bit_ready=1; a new bit restarts at phase 0.
//  5. DBPSK_DIFF_ENCODE_EN: bits 1,1,0 -> polarities -,+,+ i.e. 0,-127,0,127 | 0,127,0,-127 | 0,127,0,-127.
//  6. bit_valid held high with bit_ready=0 mid-symbol -> bit not consumed until the last sample; exactly one transfer per symbol.

Source files
------------

// File: rtl/bpsk_modulator.sv
// BPSK carrier modulator: one data bit per symbol selects the polarity of a ROM sine carrier.
// Define DBPSK_DIFF_ENCODE_EN to switch to differential (DBPSK) polarity encoding.
module bpsk_modulator #(
  parameter int unsigned SAMPLES_PER_SYMBOL = 32,
  parameter int unsigned PHASE_STEP         = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              sample_en,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic              bit_ready,
  output logic signed [7:0] sample_out,
  output logic              sample_valid,
  output logic              active
);

  typedef enum logic {ST_IDLE, ST_SYMBOL} state_t;

  localparam logic [7:0] LAST_CNT = 8'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [5:0] STEP     = 6'(PHASE_STEP);

  state_t            r_state;
  logic [5:0]        r_phase;
  logic [7:0]        r_cnt;
  logic              r_polarity;

  logic [4:0]        w_fold;
  logic [6:0]        w_mag;
  logic signed [7:0] w_pos;
  logic signed [7:0] w_sample;
  logic              w_last;
  logic              w_transfer;
  logic              w_next_pol;

  // Quarter-wave table: round(127*sin(2*pi*m/64)) for m = 0..16.
  function automatic logic [6:0] quarter_sine(input logic [4:0] m);
    case (m)
      5'd0:    quarter_sine = 7'd0;
      5'd1:    quarter_sine = 7'd12;
      5'd2:    quarter_sine = 7'd25;
      5'd3:    quarter_sine = 7'd37;
      5'd4:    quarter_sine = 7'd49;
      5'd5:    quarter_sine = 7'd60;
      5'd6:    quarter_sine = 7'd71;
      5'd7:    quarter_sine = 7'd81;
      5'd8:    quarter_sine = 7'd90;
      5'd9:    quarter_sine = 7'd98;
      5'd10:   quarter_sine = 7'd106;
      5'd11:   quarter_sine = 7'd112;
      5'd12:   quarter_sine = 7'd117;
      5'd13:   quarter_sine = 7'd122;
      5'd14:   quarter_sine = 7'd125;
      5'd15:   quarter_sine = 7'd126;
      default: quarter_sine = 7'd127;
    endcase
  endfunction

  // The 64-entry ROM is folded to a quarter wave: indices 17..31 mirror to 32-k
  // within a half period, and phase[5] selects the negative half.
  always_comb begin
    w_fold   = (r_phase[4:0] > 5'd16) ? (5'd0 - r_phase[4:0]) : r_phase[4:0];
    w_mag    = quarter_sine(w_fold);
    w_pos    = {1'b0, w_mag};
    w_sample = (r_phase[5] ^ r_polarity) ? -w_pos : w_pos;
  end

  assign w_last     = (r_cnt == LAST_CNT);
  assign bit_ready  = (r_state == ST_IDLE) || ((r_state == ST_SYMBOL) && sample_en && w_last);
  assign w_transfer = bit_valid && bit_ready;

`ifdef DBPSK_DIFF_ENCODE_EN
  assign w_next_pol = r_polarity ^ bit_in;
`else
  assign w_next_pol = bit_in;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_phase      <= '0;
      r_cnt        <= '0;
      r_polarity   <= 1'b0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      active       <= 1'b0;
    end else begin
      sample_valid <= sample_en;
      if (sample_en)
        active <= (r_state == ST_SYMBOL);
      case (r_state)
        ST_IDLE: begin
          if (sample_en)
            sample_out <= '0;
          r_phase <= '0;
          r_cnt   <= '0;
          if (w_transfer) begin
            r_state    <= ST_SYMBOL;
            r_polarity <= w_next_pol;
          end
        end
        ST_SYMBOL: begin
          if (sample_en) begin
            sample_out <= w_sample;
            r_phase    <= r_phase + STEP;
            if (w_last) begin
              r_cnt <= '0;
              if (w_transfer) begin
                r_polarity <= w_next_pol;
              end else begin
                r_state <= ST_IDLE;
`ifdef DBPSK_DIFF_ENCODE_EN
                r_polarity <= 1'b0;
`endif
              end
            end else begin
              r_cnt <= r_cnt + 8'd1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
